// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the MEM stage (size codes, FSM states,
// memory-mapped I/O addresses). Imported by mem_stage_param and dm_ram.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [31:0] SW_ADDR  = 32'h0000_FF00;
    localparam logic [31:0] LED_ADDR = 32'h0000_FF04;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Size codes 10 and 11 are both full-word accesses.
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

endpackage

// File: rtl/dm_ram.sv
// dm_ram: DEPTH x 32 data memory, byte-lane write enables, async read.
// Ports: clk, we, be[3:0], waddr, wdata (write); raddr -> rdata (read).
module dm_ram import mem_pkg::*; #(
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/mem_stage_param.sv
// mem_stage_param: MEM pipeline stage with data memory clear-on-reset (INIT),
// byte/half/word loads and stores, and the MEM/WB register.
// Inputs: clk, rst, XM_* controls, ALUout, XM_MD, XM_RD, SW.
// Outputs: MW_* (MEM/WB), MDR, MW_Misalign, LED, mem_stall.
// Optional MMIO (switches / LED registers) when MEM_STAGE_MMIO_EN is defined.
module mem_stage_param import mem_pkg::*; #(
    parameter int DM_DEPTH = 128,
    parameter int SW_WIDTH = 13
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                XM_MemtoReg,
    input  logic                XM_RegWrite,
    input  logic                XM_MemRead,
    input  logic                XM_MemWrite,
    input  logic [1:0]          XM_Size,
    input  logic                XM_Unsigned,
    input  logic [31:0]         ALUout,
    input  logic [31:0]         XM_MD,
    input  logic [4:0]          XM_RD,
    input  logic [SW_WIDTH-1:0] SW,
    output logic                MW_MemtoReg,
    output logic                MW_RegWrite,
    output logic [31:0]         MW_ALUout,
    output logic [31:0]         MDR,
    output logic [4:0]          MW_RD,
    output logic                MW_Misalign,
    output logic [SW_WIDTH-1:0] LED,
    output logic                mem_stall
);

    localparam int AW = $clog2(DM_DEPTH);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          mw_mtr_q, mw_mtr_d;
    logic          mw_rw_q, mw_rw_d;
    logic [31:0]   mw_alu_q, mw_alu_d;
    logic [4:0]    mw_rd_q, mw_rd_d;
    logic          mis_q, mis_d;
    logic [31:0]   mdr_q, mdr_d;

    logic [1:0]    lane;
    logic [AW-1:0] idx;
    logic          word_sz, misal, store_ok, load_ok;
    logic          sw_hit, led_hit;
    logic [31:0]   sw_ext, rdata, load_val;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic          we;
    logic [3:0]    be;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;

    assign lane    = ALUout[1:0];
    assign idx     = ALUout[AW+1:2];
    assign word_sz = is_word(XM_Size);

    always_comb begin
        sw_ext = '0;
        sw_ext[SW_WIDTH-1:0] = SW;
    end

    // Only real memory accesses can be misaligned.
    assign misal = (XM_MemRead | XM_MemWrite)
                 & (((XM_Size == SZ_HALF) & ALUout[0])
                 | (word_sz & (|ALUout[1:0])));

    assign store_ok = XM_MemWrite & ~misal;
    assign load_ok  = XM_MemRead & ~XM_MemWrite & ~misal;

`ifdef MEM_STAGE_MMIO_EN
    assign sw_hit  = word_sz & (ALUout == SW_ADDR);
    assign led_hit = word_sz & (ALUout == LED_ADDR);
`else
    logic unused_addr;
    assign sw_hit      = 1'b0;
    assign led_hit     = 1'b0;
    assign unused_addr = &{1'b0, ALUout[31:AW+2]};
`endif

    // Write port: INIT sweep has priority, then pipeline stores.
    always_comb begin
        we    = 1'b0;
        be    = 4'h0;
        waddr = idx;
        wdata = XM_MD;
        if (state_q == INIT) begin
            we    = 1'b1;
            be    = 4'hF;
            waddr = cnt_q;
            wdata = (cnt_q[AW-1:1] == '0) ? sw_ext : 32'h0;
        end else if (store_ok & ~led_hit) begin
            we = 1'b1;
            unique case (1'b1)
                XM_Size == SZ_BYTE: begin
                    be    = 4'b0001 << lane;
                    wdata = {4{XM_MD[7:0]}};
                end
                XM_Size == SZ_HALF: begin
                    be    = ALUout[1] ? 4'b1100 : 4'b0011;
                    wdata = {2{XM_MD[15:0]}};
                end
                word_sz: be = 4'hF;
            endcase
        end
        we = we & ~rst;
    end

    dm_ram #(
        .DEPTH (DM_DEPTH),
        .AW    (AW)
    ) u_dm (
        .clk   (clk),
        .we    (we),
        .be    (be),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (idx),
        .rdata (rdata)
    );

    assign rd_byte = rdata[{lane, 3'b000} +: 8];
    assign rd_half = ALUout[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        load_val = rdata;
        unique case (1'b1)
            XM_Size == SZ_BYTE:
                load_val = {{24{rd_byte[7] & ~XM_Unsigned}}, rd_byte};
            XM_Size == SZ_HALF:
                load_val = {{16{rd_half[15] & ~XM_Unsigned}}, rd_half};
            word_sz:
                load_val = sw_hit ? sw_ext : rdata;
        endcase
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == AW'(DM_DEPTH - 1)) begin
                state_d = RUN;
            end
        end
    end

    // FSM output.
    always_comb begin
        mem_stall = (state_q == INIT);
    end

    // MEM/WB register next values; cleared while INIT runs.
    always_comb begin
        mw_mtr_d = 1'b0;
        mw_rw_d  = 1'b0;
        mw_alu_d = '0;
        mw_rd_d  = '0;
        mis_d    = 1'b0;
        mdr_d    = mdr_q;
        if (state_q == RUN) begin
            mw_mtr_d = XM_MemtoReg;
            mw_rw_d  = XM_RegWrite & ~misal;
            mw_alu_d = ALUout;
            mw_rd_d  = XM_RD;
            mis_d    = misal;
            if (load_ok) begin
                mdr_d = load_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= INIT;
            cnt_q    <= '0;
            mw_mtr_q <= 1'b0;
            mw_rw_q  <= 1'b0;
            mw_alu_q <= '0;
            mw_rd_q  <= '0;
            mis_q    <= 1'b0;
            mdr_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mw_mtr_q <= mw_mtr_d;
            mw_rw_q  <= mw_rw_d;
            mw_alu_q <= mw_alu_d;
            mw_rd_q  <= mw_rd_d;
            mis_q    <= mis_d;
            mdr_q    <= mdr_d;
        end
    end

`ifdef MEM_STAGE_MMIO_EN
    logic [SW_WIDTH-1:0] led_q, led_d;

    always_comb begin
        led_d = led_q;
        if (state_q == RUN && store_ok && led_hit) begin
            led_d = XM_MD[SW_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    assign LED = led_q;
`else
    assign LED = '0;
`endif

    assign MW_MemtoReg = mw_mtr_q;
    assign MW_RegWrite = mw_rw_q;
    assign MW_ALUout   = mw_alu_q;
    assign MW_RD       = mw_rd_q;
    assign MW_Misalign = mis_q;
    assign MDR         = mdr_q;

endmodule

// File: tb/tb_mem_stage_param.sv
// tb_mem_stage_param: directed stimulus, byte-array reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_mem_stage_param;

    localparam int DEPTH = 128;
    localparam int SWW   = 13;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            XM_MemtoReg = 1'b0, XM_RegWrite = 1'b0;
    logic            XM_MemRead = 1'b0, XM_MemWrite = 1'b0;
    logic [1:0]      XM_Size = 2'b10;
    logic            XM_Unsigned = 1'b0;
    logic [31:0]     ALUout = '0, XM_MD = '0;
    logic [4:0]      XM_RD = '0;
    logic [SWW-1:0]  SW = 13'h1ABC;
    logic            MW_MemtoReg, MW_RegWrite, MW_Misalign, mem_stall;
    logic [31:0]     MW_ALUout, MDR;
    logic [4:0]      MW_RD;
    logic [SWW-1:0]  LED;

    always #5 clk = ~clk;

    mem_stage_param #(.DM_DEPTH(DEPTH), .SW_WIDTH(SWW)) dut (
        .clk(clk), .rst(rst),
        .XM_MemtoReg(XM_MemtoReg), .XM_RegWrite(XM_RegWrite),
        .XM_MemRead(XM_MemRead), .XM_MemWrite(XM_MemWrite),
        .XM_Size(XM_Size), .XM_Unsigned(XM_Unsigned),
        .ALUout(ALUout), .XM_MD(XM_MD), .XM_RD(XM_RD), .SW(SW),
        .MW_MemtoReg(MW_MemtoReg), .MW_RegWrite(MW_RegWrite),
        .MW_ALUout(MW_ALUout), .MDR(MDR), .MW_RD(MW_RD),
        .MW_Misalign(MW_Misalign), .LED(LED), .mem_stall(mem_stall)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: byte-addressed memory and expected register values.
    logic [7:0]     m_mem [4*DEPTH];
    bit             m_valid = 0, m_init = 1;
    int             m_cnt = 0;
    logic           e_mtr, e_rw, e_mis;
    logic [31:0]    e_alu, e_mdr, v, swx;
    logic [4:0]     e_rd;
    logic [SWW-1:0] e_led;
    int             ba, nb;
    bit             mis, sw_hit, led_hit;

    always @(posedge clk) begin
        swx = 32'(SW);
        if (rst) begin
            m_valid = 1; m_init = 1; m_cnt = 0;
            e_mtr = 0; e_rw = 0; e_mis = 0;
            e_alu = 0; e_rd = 0; e_mdr = 0; e_led = 0;
        end else if (m_valid && m_init) begin
            for (int k = 0; k < 4; k++)
                m_mem[4*m_cnt+k] = (m_cnt < 2) ? swx[8*k +: 8] : 8'h00;
            m_cnt++;
            if (m_cnt == DEPTH) m_init = 0;
            e_mtr = 0; e_rw = 0; e_mis = 0; e_alu = 0; e_rd = 0;
        end else if (m_valid) begin
            nb = (XM_Size == 2'd0) ? 1 : (XM_Size == 2'd1) ? 2 : 4;
            ba = int'(ALUout & 32'(4*DEPTH - 1));
            mis = (XM_MemRead || XM_MemWrite) && (ALUout % nb != 0);
            sw_hit = 0; led_hit = 0;
`ifdef MEM_STAGE_MMIO_EN
            sw_hit  = (nb == 4) && (ALUout == 32'h0000_FF00);
            led_hit = (nb == 4) && (ALUout == 32'h0000_FF04);
`endif
            if (XM_MemWrite && !mis) begin
                if (led_hit) e_led = XM_MD[SWW-1:0];
                else for (int k = 0; k < nb; k++)
                    m_mem[ba+k] = XM_MD[8*k +: 8];
            end else if (XM_MemRead && !mis) begin
                v = 0;
                if (sw_hit) v = swx;
                else for (int k = 0; k < nb; k++) v[8*k +: 8] = m_mem[ba+k];
                if (!XM_Unsigned && nb < 4 && v[8*nb-1])
                    for (int k = nb; k < 4; k++) v[8*k +: 8] = 8'hFF;
                e_mdr = v;
            end
            e_mtr = XM_MemtoReg; e_rw = XM_RegWrite && !mis;
            e_alu = ALUout; e_rd = XM_RD; e_mis = mis;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("stall", 32'(mem_stall), 32'(m_init));
            chk("mw_mtr", 32'(MW_MemtoReg), 32'(e_mtr));
            chk("mw_rw", 32'(MW_RegWrite), 32'(e_rw));
            chk("mw_alu", MW_ALUout, e_alu);
            chk("mw_rd", 32'(MW_RD), 32'(e_rd));
            chk("mdr", MDR, e_mdr);
            chk("mis", 32'(MW_Misalign), 32'(e_mis));
            chk("led", 32'(LED), 32'(e_led));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic count_stall(output int n);
        n = 0;
        while (mem_stall === 1'b1 && n < 300) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic op(input bit rd, input bit wr, input logic [1:0] sz,
                      input bit uns, input logic [31:0] addr,
                      input logic [31:0] md, input bit rw);
        @(negedge clk);
        XM_MemRead = rd; XM_MemWrite = wr; XM_Size = sz;
        XM_Unsigned = uns; ALUout = addr; XM_MD = md;
        XM_RegWrite = rw; XM_MemtoReg = rd; XM_RD = 5'(addr[6:2] + 1);
        @(posedge clk);
        #1;
        XM_MemRead = 0; XM_MemWrite = 0; XM_RegWrite = 0; XM_MemtoReg = 0;
    endtask

    int n;

    initial begin
        do_reset();
        // Garbage EX/MEM controls during INIT must be ignored.
        XM_RegWrite = 1; XM_MemWrite = 1; XM_MemtoReg = 1;
        ALUout = 32'h8; XM_MD = 32'hDEAD_BEEF;
        repeat (50) @(posedge clk);
        #1;
        chk("init_rw", 32'(MW_RegWrite), 32'h0);
        chk("init_stall", 32'(mem_stall), 32'h1);
        do_reset();
        count_stall(n);
        XM_RegWrite = 0; XM_MemWrite = 0; XM_MemtoReg = 0;
        chk("stall_len", 32'(n), 32'd128);

        op(1, 0, 2'b10, 0, 32'h0, 0, 1);
        chk("ld_w0", MDR, 32'h0000_1ABC);
        chk("mw_alu_lit", MW_ALUout, 32'h0);
        op(1, 0, 2'b10, 0, 32'h4, 0, 1);
        chk("ld_w1", MDR, 32'h0000_1ABC);
        op(1, 0, 2'b11, 0, 32'h8, 0, 1);
        chk("ld_w2", MDR, 32'h0);

        op(0, 1, 2'b10, 0, 32'h10, 32'h80FF_7F01, 0);
        op(1, 0, 2'b00, 0, 32'h13, 0, 1);
        chk("lb_13", MDR, 32'hFFFF_FF80);
        op(1, 0, 2'b00, 1, 32'h11, 0, 1);
        chk("lbu_11", MDR, 32'h0000_007F);
        op(1, 0, 2'b01, 0, 32'h12, 0, 1);
        chk("lh_12", MDR, 32'hFFFF_80FF);
        op(1, 0, 2'b01, 1, 32'h12, 0, 1);
        chk("lhu_12", MDR, 32'h0000_80FF);

        op(0, 1, 2'b00, 0, 32'h15, 32'h1234_56AA, 0);
        op(0, 1, 2'b01, 0, 32'h16, 32'h5678_BEEF, 0);
        op(1, 0, 2'b10, 0, 32'h14, 0, 1);
        chk("sb_sh", MDR, 32'hBEEF_AA00);

        op(0, 1, 2'b10, 0, 32'h20, 32'hCAFE_F00D, 0);
        op(0, 1, 2'b01, 0, 32'h21, 32'h0000_1111, 1);
        chk("mis_flag", 32'(MW_Misalign), 32'h1);
        chk("mis_rw", 32'(MW_RegWrite), 32'h0);
        @(posedge clk);
        #1;
        chk("mis_clear", 32'(MW_Misalign), 32'h0);
        op(1, 0, 2'b10, 0, 32'h20, 0, 1);
        chk("mis_nowr", MDR, 32'hCAFE_F00D);
        op(1, 0, 2'b10, 0, 32'h22, 0, 1);
        chk("mis_ld_hold", MDR, 32'hCAFE_F00D);

        op(1, 1, 2'b10, 0, 32'h30, 32'h5555_AAAA, 1);
        chk("rw_hold", MDR, 32'hCAFE_F00D);
        op(1, 0, 2'b10, 0, 32'h30, 0, 1);
        chk("rw_wrote", MDR, 32'h5555_AAAA);

        op(0, 1, 2'b10, 0, 32'h200, 32'h0000_1234, 0);
        op(1, 0, 2'b10, 0, 32'h0, 0, 1);
        chk("wrap", MDR, 32'h0000_1234);

        SW = 13'h0055;
        op(0, 1, 2'b10, 0, 32'hFF04, 32'h0000_1FFF, 0);
`ifdef MEM_STAGE_MMIO_EN
        chk("led_set", 32'(LED), 32'h1FFF);
        op(1, 0, 2'b10, 0, 32'hFF00, 0, 1);
        chk("sw_rd", MDR, 32'h0000_0055);
        op(1, 0, 2'b10, 0, 32'h104, 0, 1);
        chk("led_no_dm", MDR, 32'h0);
`else
        chk("led_off", 32'(LED), 32'h0);
        op(1, 0, 2'b10, 0, 32'h104, 0, 1);
        chk("dm_alias", MDR, 32'h0000_1FFF);
        op(1, 0, 2'b10, 0, 32'hFF00, 0, 1);
        chk("sw_no_mmio", MDR, 32'h0);
`endif

        do_reset();
        chk("rst_mdr", MDR, 32'h0);
        chk("rst_alu", MW_ALUout, 32'h0);
        chk("rst_led", 32'(LED), 32'h0);
        chk("rst_stall", 32'(mem_stall), 32'h1);
        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
